sram_bus_responder: RTL and testbench

- Responder end of the Z80 computer's external memory bus (addr/dat/we/cs/ack initiator handshake).
- Turns each initiator request into a correctly timed asynchronous SRAM cycle with configurable wait states.
- Drives the 18-bit SRAM address, the chip-select/output-enable/write-enable strobes and the bidirectional data split; returns a one-cycle ack.
- Replaces the fixed ack-always-high and free-running wait-counter schemes.

---
 rtl/sram_bus_pkg.sv | 20 ++
 rtl/sram_wait_ctr.sv | 30 +++
 rtl/sram_bus_responder.sv | 138 +++++++++++++
 tb/tb_sram_bus_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the external SRAM bus responder.
package sram_bus_pkg;

  // Responder state; 3-bit encoding, IDLE is the reset state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4,
    S_ACK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int WAIT_W   = 4;   // wait-state counter width
  localparam int MIN_WAIT = 1;   // smallest legal strobe length
  localparam int MAX_WAIT = 15;  // largest value the counter can hold
  localparam int SRAM_AW  = 18;  // {bank, cpu address}

endpackage

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter that flags the last cycle of a strobe.
// last is high while the count equals 1, so a strobe of N cycles ends
// when the counter has been enabled for N cycles after a load of N.
module sram_wait_ctr
  import sram_bus_pkg::*;
(
  input  logic              clk25mhz,
  input  logic              resetn,
  input  logic              load,
  input  logic [WAIT_W-1:0] value,
  input  logic              en,
  output logic              last
);

  logic [WAIT_W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk25mhz) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign last = (count == WAIT_W'(1));

endmodule

// File: rtl/sram_bus_responder.sv
// Responder end of the Z80 external memory bus: converts one initiator
// request into a timed asynchronous SRAM cycle and returns a one-cycle ack.
//
// Handshake: the initiator raises i_cs with i_we/i_addr/i_bank/i_dat stable;
// those are sampled only in the IDLE cycle that sees i_cs=1. The responder
// pulses o_ack for exactly one cycle when the SRAM cycle is complete (o_dat
// valid on reads). A new request is accepted only after i_cs has been low
// for at least one cycle, so a held i_cs never retriggers; dropping i_cs
// early never truncates the SRAM cycle.
module sram_bus_responder
  import sram_bus_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic               clk25mhz,
  input  logic               resetn,
  input  logic               i_cs,
  input  logic               i_we,
  input  logic [15:0]        i_addr,
  input  logic [1:0]         i_bank,
  input  logic [7:0]         i_dat,
  output logic [7:0]         o_dat,
  output logic               o_ack,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [7:0]         o_sram_dout,
  output logic               o_sram_doe,
  input  logic [7:0]         i_sram_din,
  output logic               o_sram_cs_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n
);

  if ((RD_WAIT < MIN_WAIT) || (RD_WAIT > MAX_WAIT)) begin : g_bad_rd_wait
    $error("sram_bus_responder: RD_WAIT out of range 1..15");
  end
  if ((WR_WAIT < MIN_WAIT) || (WR_WAIT > MAX_WAIT)) begin : g_bad_wr_wait
    $error("sram_bus_responder: WR_WAIT out of range 1..15");
  end

  localparam logic [WAIT_W-1:0] RD_CNT = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_CNT = WAIT_W'(WR_WAIT);

  state_t state, next_state;
  logic   we_l;
  logic   req_we;       // direction of the cycle being set up
  logic   ctr_load, ctr_en, ctr_last;
  logic   capture;
  logic   ack_d, cs_n_d, oe_n_d, we_n_d, doe_d;

  sram_wait_ctr u_wait_ctr (
    .clk25mhz (clk25mhz),
    .resetn   (resetn),
    .load     (ctr_load),
    .value    (i_we ? WR_CNT : RD_CNT),
    .en       (ctr_en),
    .last     (ctr_last)
  );

  // Next state, plus strobe values decoded from the state being entered so
  // that every SRAM strobe leaves a flop.
  always_comb begin
    next_state = state;
    req_we     = (state == S_IDLE) ? i_we : we_l;
    ctr_load   = 1'b0;
    ctr_en     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_cs) begin
          next_state = S_SETUP;
          ctr_load   = 1'b1;
        end
      end
      S_SETUP: next_state = we_l ? S_WRITE : S_READ;
      S_READ: begin
        ctr_en = 1'b1;
        if (ctr_last) begin
          capture    = 1'b1;
          next_state = S_ACK;
        end
      end
      S_WRITE: begin
        ctr_en = 1'b1;
        if (ctr_last) next_state = S_HOLD;
      end
      S_HOLD:  next_state = S_ACK;
      S_ACK:   next_state = S_DONE;
      S_DONE:  if (!i_cs) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    ack_d  = (next_state == S_ACK);
    cs_n_d = !((next_state == S_SETUP) || (next_state == S_READ) ||
               (next_state == S_WRITE) || (next_state == S_HOLD));
    oe_n_d = !(((next_state == S_SETUP) && !req_we) || (next_state == S_READ));
    we_n_d = !(next_state == S_WRITE);
    doe_d  = ((next_state == S_SETUP) && req_we) ||
             (next_state == S_WRITE) || (next_state == S_HOLD);
  end

  // State and strobe registers; reset abandons any cycle in flight.
  always_ff @(posedge clk25mhz) begin
    if (!resetn) begin
      state       <= S_IDLE;
      o_ack       <= 1'b0;
      o_sram_cs_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_doe  <= 1'b0;
    end else begin
      state       <= next_state;
      o_ack       <= ack_d;
      o_sram_cs_n <= cs_n_d;
      o_sram_oe_n <= oe_n_d;
      o_sram_we_n <= we_n_d;
      o_sram_doe  <= doe_d;
    end
  end

  // Request latch in IDLE and read-data capture on the last READ cycle.
  always_ff @(posedge clk25mhz) begin
    if (!resetn) begin
      o_sram_addr <= '0;
      o_sram_dout <= '0;
      we_l        <= 1'b0;
      o_dat       <= '0;
    end else begin
      if (ctr_load) begin
        o_sram_addr <= {i_bank, i_addr};
        o_sram_dout <= i_dat;
        we_l        <= i_we;
      end
      if (capture) o_dat <= i_sram_din;
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench: default instance (a) and RD_WAIT=1/WR_WAIT=5 instance (b),
// each attached to a behavioural SRAM model. All checks run at negedge.
module tb_sram_bus_responder;
  import sram_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk25mhz = 1'b0;
  logic resetn   = 1'b0;
  always #20 clk25mhz = ~clk25mhz;

  // shared request fields, separate chip selects
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic        i_we = 1'b0;
  logic [15:0] i_addr = '0;
  logic [1:0]  i_bank = '0;
  logic [7:0]  i_dat = '0;

  logic [7:0]  a_dat, a_dout, a_din, b_dat, b_dout, b_din;
  logic [17:0] a_addr, b_addr;
  logic        a_ack, a_doe, a_cs_n, a_oe_n, a_we_n;
  logic        b_ack, b_doe, b_cs_n, b_oe_n, b_we_n;

  sram_bus_responder dut_a (
    .clk25mhz(clk25mhz), .resetn(resetn), .i_cs(cs_a), .i_we(i_we),
    .i_addr(i_addr), .i_bank(i_bank), .i_dat(i_dat), .o_dat(a_dat),
    .o_ack(a_ack), .o_sram_addr(a_addr), .o_sram_dout(a_dout),
    .o_sram_doe(a_doe), .i_sram_din(a_din), .o_sram_cs_n(a_cs_n),
    .o_sram_oe_n(a_oe_n), .o_sram_we_n(a_we_n)
  );

  sram_bus_responder #(.RD_WAIT(1), .WR_WAIT(5)) dut_b (
    .clk25mhz(clk25mhz), .resetn(resetn), .i_cs(cs_b), .i_we(i_we),
    .i_addr(i_addr), .i_bank(i_bank), .i_dat(i_dat), .o_dat(b_dat),
    .o_ack(b_ack), .o_sram_addr(b_addr), .o_sram_dout(b_dout),
    .o_sram_doe(b_doe), .i_sram_din(b_din), .o_sram_cs_n(b_cs_n),
    .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n)
  );

  // ---------------- SRAM models ----------------
  logic [7:0] mem_a [0:262143];
  logic [7:0] mem_b [0:262143];

  assign a_din = (!a_cs_n && !a_oe_n) ? mem_a[a_addr] : 8'hEE;
  assign b_din = (!b_cs_n && !b_oe_n) ? mem_b[b_addr] : 8'hEE;

  always @(posedge clk25mhz) begin
    if (!a_cs_n && !a_we_n) mem_a[a_addr] <= a_dout;
    if (!b_cs_n && !b_we_n) mem_b[b_addr] <= b_dout;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int acks;
  int wlow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_a(input logic we, input logic [1:0] bank, input logic [15:0] addr,
                         input logic [7:0] dat);
    check("a_idle_before", 32'(dut_a.state), 32'(S_IDLE));
    i_we = we; i_bank = bank; i_addr = addr; i_dat = dat; cs_a = 1'b1;
  endtask

  task automatic start_b(input logic we, input logic [1:0] bank, input logic [15:0] addr,
                         input logic [7:0] dat);
    check("b_idle_before", 32'(dut_b.state), 32'(S_IDLE));
    i_we = we; i_bank = bank; i_addr = addr; i_dat = dat; cs_b = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[18'h11234] = 8'hA5;
    mem_b[18'h2BEEF] = 8'hC3;

    // reset values
    repeat (3) @(negedge clk25mhz);
    check("rst_ack",  32'(a_ack),  0);
    check("rst_dat",  32'(a_dat),  0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_doe",  32'(a_doe),  0);
    check("rst_cs_n", 32'(a_cs_n), 1);
    check("rst_oe_n", 32'(a_oe_n), 1);
    check("rst_we_n", 32'(a_we_n), 1);
    check("rst_state", 32'(dut_a.state), 32'(S_IDLE));
    resetn = 1'b1;

    // read with defaults, i_cs held for 20 cycles afterwards
    @(negedge clk25mhz);
    start_a(1'b0, 2'b01, 16'h1234, 8'h00);
    acks = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk25mhz);
      if (c <= 5) begin
        check("rd_oe_n", 32'(a_oe_n), (c <= 3) ? 0 : 1);
        check("rd_cs_n", 32'(a_cs_n), (c <= 3) ? 0 : 1);
        check("rd_doe",  32'(a_doe),  0);
        check("rd_ack",  32'(a_ack),  (c == 4) ? 1 : 0);
      end
      if (c == 1) check("rd_addr", 32'(a_addr), 32'h11234);
      if (c == 4) check("rd_dat",  32'(a_dat),  32'hA5);
      if (a_ack) acks++;
    end
    check("held_acks",  acks, 1);
    check("held_state", 32'(dut_a.state), 32'(S_DONE));
    cs_a = 1'b0;
    @(negedge clk25mhz);
    start_a(1'b0, 2'b01, 16'h1234, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk25mhz);
      check("rd2_ack", 32'(a_ack), (c == 4) ? 1 : 0);
      if (c == 4) begin
        check("rd2_dat", 32'(a_dat), 32'hA5);
        cs_a = 1'b0;
      end
    end

    // write with defaults; request fields change mid-cycle and must be ignored
    @(negedge clk25mhz);
    start_a(1'b1, 2'b00, 16'h00FF, 8'h3C);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk25mhz);
      check("wr_we_n", 32'(a_we_n), (c >= 2 && c <= 3) ? 0 : 1);
      check("wr_doe",  32'(a_doe),  (c <= 4) ? 1 : 0);
      check("wr_cs_n", 32'(a_cs_n), (c <= 4) ? 0 : 1);
      check("wr_oe_n", 32'(a_oe_n), 1);
      check("wr_ack",  32'(a_ack),  (c == 5) ? 1 : 0);
      if (c == 2) begin
        i_addr = 16'hFFFF; i_dat = 8'h00; i_bank = 2'b11; i_we = 1'b0;
      end
      if (c == 4) begin
        check("wr_dout", 32'(a_dout), 32'h3C);
        check("wr_addr", 32'(a_addr), 32'h000FF);
      end
      if (c == 5) cs_a = 1'b0;
    end
    check("wr_mem", 32'(mem_a[18'h000FF]), 32'h3C);

    // i_cs dropped during READ
    @(negedge clk25mhz);
    start_a(1'b0, 2'b01, 16'h1234, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk25mhz);
      check("drop_oe_n", 32'(a_oe_n), (c <= 3) ? 0 : 1);
      check("drop_ack",  32'(a_ack),  (c == 4) ? 1 : 0);
      if (c == 2) cs_a = 1'b0;
      if (c == 4) check("drop_dat", 32'(a_dat), 32'hA5);
      if (c == 5) check("drop_done", 32'(dut_a.state), 32'(S_DONE));
      if (c == 6) check("drop_idle", 32'(dut_a.state), 32'(S_IDLE));
    end

    // reset during WRITE, then a fresh write
    @(negedge clk25mhz);
    start_a(1'b1, 2'b00, 16'h0042, 8'h5A);
    @(negedge clk25mhz);
    check("rstw_doe1", 32'(a_doe), 1);
    @(negedge clk25mhz);
    check("rstw_we_low", 32'(a_we_n), 0);
    resetn = 1'b0;
    cs_a = 1'b0;
    @(negedge clk25mhz);
    check("rstw_we_n",  32'(a_we_n), 1);
    check("rstw_cs_n",  32'(a_cs_n), 1);
    check("rstw_doe",   32'(a_doe),  0);
    check("rstw_ack",   32'(a_ack),  0);
    check("rstw_state", 32'(dut_a.state), 32'(S_IDLE));
    resetn = 1'b1;
    @(negedge clk25mhz);
    start_a(1'b1, 2'b00, 16'h0042, 8'h77);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk25mhz);
      check("rstw2_ack",  32'(a_ack),  (c == 5) ? 1 : 0);
      check("rstw2_we_n", 32'(a_we_n), (c >= 2 && c <= 3) ? 0 : 1);
      if (c == 5) cs_a = 1'b0;
    end
    check("rstw2_mem", 32'(mem_a[18'h00042]), 32'h77);

    // RD_WAIT=1 / WR_WAIT=5 instance
    @(negedge clk25mhz);
    start_b(1'b0, 2'b10, 16'hBEEF, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk25mhz);
      check("b_rd_oe_n", 32'(b_oe_n), (c <= 2) ? 0 : 1);
      check("b_rd_ack",  32'(b_ack),  (c == 3) ? 1 : 0);
      if (c == 3) begin
        check("b_rd_dat", 32'(b_dat), 32'hC3);
        cs_b = 1'b0;
      end
    end
    @(negedge clk25mhz);
    start_b(1'b1, 2'b11, 16'h0010, 8'h96);
    wlow = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk25mhz);
      check("b_wr_we_n", 32'(b_we_n), (c >= 2 && c <= 6) ? 0 : 1);
      check("b_wr_doe",  32'(b_doe),  (c <= 7) ? 1 : 0);
      check("b_wr_ack",  32'(b_ack),  (c == 8) ? 1 : 0);
      if (!b_we_n) wlow++;
      if (c == 8) cs_b = 1'b0;
    end
    check("b_wr_wlow", wlow, 5);
    check("b_wr_mem", 32'(mem_b[18'h30010]), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
